// File: rtl/mlblock_seq_ctrl.sv
// Sequencer for one ML block: optional config-chain reload, weight shift, accumulate, drain.
// Define MLB_SEQ_STALL_EN to add the stall input that freezes the CFG/W/ACC phases.
module mlblock_seq_ctrl #(
    parameter int unsigned CFG_LEN  = 8,
    parameter int unsigned CNT_W    = 8,
    parameter int unsigned PIPE_LAT = 3
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic               cfg_reload,
    input  logic [CFG_LEN-1:0] cfg_word,
    input  logic [CNT_W-1:0]   w_cycles,
    input  logic [CNT_W-1:0]   acc_cycles,
`ifdef MLB_SEQ_STALL_EN
    input  logic               stall,
`endif
    output logic               busy,
    output logic               done,
    output logic               out_valid,
    output logic               config_en,
    output logic               config_in,
    output logic               W_en,
    output logic               I_en,
    output logic               Res_en,
    output logic               Res_cas_in_zero
);

    localparam int unsigned CFG_CW    = $clog2(CFG_LEN + 1);
    localparam int unsigned CW        = (CNT_W > CFG_CW) ? CNT_W : CFG_CW;
    localparam int unsigned DRAIN_LEN = (PIPE_LAT == 0) ? 1 : PIPE_LAT;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CFG,
        S_WLOAD,
        S_ACCUM,
        S_DRAIN
    } state_t;

    state_t               r_state, w_state_nxt;
    logic [CW-1:0]        r_cnt, w_cnt_nxt;
    logic [CFG_LEN-1:0]   r_sr, w_sr_nxt;
    logic [CNT_W-1:0]     r_w, w_w_nxt;
    logic [CNT_W-1:0]     r_acc, w_acc_nxt;
    logic                 w_stall;
    logic                 w_last;

    logic r_busy, r_done, r_cfg_en, r_cfg_in, r_w_en, r_i_en, r_rcz;
    logic w_busy_nxt, w_done_nxt, w_cfg_en_nxt, w_cfg_in_nxt, w_w_en_nxt, w_i_en_nxt, w_rcz_nxt;

`ifdef MLB_SEQ_STALL_EN
    assign w_stall = stall && (r_state inside {S_CFG, S_WLOAD, S_ACCUM});
`else
    assign w_stall = 1'b0;
`endif

    assign w_last = (r_cnt == CW'(1));

    function automatic logic [CW-1:0] f_acc_load(input logic [CNT_W-1:0] n);
        return (n == '0) ? CW'(1) : CW'(n);
    endfunction

    // Registers describe the step being emitted this cycle; a stall holds them and emits a bubble.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_sr_nxt    = r_sr;
        w_w_nxt     = r_w;
        w_acc_nxt   = r_acc;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_sr_nxt  = cfg_word;
                    w_w_nxt   = w_cycles;
                    w_acc_nxt = acc_cycles;
                    if (cfg_reload) begin
                        w_state_nxt = S_CFG;
                        w_cnt_nxt   = CW'(CFG_LEN);
                    end else if (w_cycles != '0) begin
                        w_state_nxt = S_WLOAD;
                        w_cnt_nxt   = CW'(w_cycles);
                    end else begin
                        w_state_nxt = S_ACCUM;
                        w_cnt_nxt   = f_acc_load(acc_cycles);
                    end
                end
            end
            S_CFG: begin
                if (!w_stall) begin
                    if (w_last) begin
                        if (r_w != '0) begin
                            w_state_nxt = S_WLOAD;
                            w_cnt_nxt   = CW'(r_w);
                        end else begin
                            w_state_nxt = S_ACCUM;
                            w_cnt_nxt   = f_acc_load(r_acc);
                        end
                    end else begin
                        w_cnt_nxt = r_cnt - CW'(1);
                        w_sr_nxt  = r_sr << 1;
                    end
                end
            end
            S_WLOAD: begin
                if (!w_stall) begin
                    if (w_last) begin
                        w_state_nxt = S_ACCUM;
                        w_cnt_nxt   = f_acc_load(r_acc);
                    end else begin
                        w_cnt_nxt = r_cnt - CW'(1);
                    end
                end
            end
            S_ACCUM: begin
                if (!w_stall) begin
                    if (w_last) begin
                        w_state_nxt = S_DRAIN;
                        w_cnt_nxt   = CW'(DRAIN_LEN);
                    end else begin
                        w_cnt_nxt = r_cnt - CW'(1);
                    end
                end
            end
            S_DRAIN: begin
                if (w_last) begin
                    w_state_nxt = S_IDLE;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt = r_cnt - CW'(1);
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_cnt_nxt   = '0;
            end
        endcase

        w_busy_nxt   = (w_state_nxt != S_IDLE);
        w_cfg_en_nxt = (w_state_nxt == S_CFG) && !w_stall;
        w_cfg_in_nxt = w_cfg_en_nxt && w_sr_nxt[CFG_LEN-1];
        w_w_en_nxt   = (w_state_nxt == S_WLOAD) && !w_stall;
        w_i_en_nxt   = (w_state_nxt == S_ACCUM) && !w_stall;
        // Entering ACCUM only happens on a non-stalled step, so this marks the first effective cycle.
        w_rcz_nxt    = (w_state_nxt == S_ACCUM) && (r_state != S_ACCUM);
        w_done_nxt   = (w_state_nxt == S_DRAIN) && (w_cnt_nxt == CW'(1));
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= S_IDLE;
            r_cnt    <= '0;
            r_sr     <= '0;
            r_w      <= '0;
            r_acc    <= '0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_cfg_en <= 1'b0;
            r_cfg_in <= 1'b0;
            r_w_en   <= 1'b0;
            r_i_en   <= 1'b0;
            r_rcz    <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_cnt    <= w_cnt_nxt;
            r_sr     <= w_sr_nxt;
            r_w      <= w_w_nxt;
            r_acc    <= w_acc_nxt;
            r_busy   <= w_busy_nxt;
            r_done   <= w_done_nxt;
            r_cfg_en <= w_cfg_en_nxt;
            r_cfg_in <= w_cfg_in_nxt;
            r_w_en   <= w_w_en_nxt;
            r_i_en   <= w_i_en_nxt;
            r_rcz    <= w_rcz_nxt;
        end
    end

    assign busy            = r_busy;
    assign done            = r_done;
    assign out_valid       = r_done;
    assign config_en       = r_cfg_en;
    assign config_in       = r_cfg_in;
    assign W_en            = r_w_en;
    assign I_en            = r_i_en;
    assign Res_en          = r_i_en;
    assign Res_cas_in_zero = r_rcz;

endmodule
